sample_sequencer: RTL and testbench

SAMPLE_SEQUENCER -- requirements
Module: sample_sequencer

---
 rtl/sample_sequencer.sv | 132 +++++++++++++
 tb/tb_sample_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sample_sequencer.sv
// SPI-framed coefficient loader and sample sequencer feeding a 3-tap FIR.
// Optional filter watchdog enabled by defining SEQ_WATCHDOG_EN.
module sample_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ss_n,
  input  logic [9:0]  rx_word,
  input  logic        coef_reload,
  input  logic [9:0]  filtered,
  input  logic        filt_done,
  output logic [29:0] coef,
  output logic        coef_valid,
  output logic [9:0]  sample,
  output logic        sample_valid,
  output logic [9:0]  tx_word,
  output logic        busy,
  output logic        overrun,
  output logic        timeout
);

  typedef enum logic [1:0] {COEF, STREAM, PROC} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic                   ss_d;
  logic                   fe;
  logic [1:0]             idx;
  logic                   wd_exp;

  // Flops preset to 1 so a reset release with ss_n high never looks like a frame end.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ss_sync <= '1;
      ss_d    <= 1'b1;
    end else begin
      ss_sync <= {ss_sync[SYNC_STAGES-2:0], ss_n};
      ss_d    <= ss_sync[SYNC_STAGES-1];
    end
  end

  assign fe = ss_sync[SYNC_STAGES-1] & ~ss_d;

`ifdef SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  // Held at zero outside PROC, so it starts cleared on every PROC entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             wd_cnt <= '0;
    else if (state != PROC) wd_cnt <= '0;
    else                    wd_cnt <= wd_cnt + 1'b1;
  end

  assign wd_exp = (state == PROC) && !filt_done &&
                  (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           timeout <= 1'b0;
    else if (coef_reload) timeout <= 1'b0;
    else if (wd_exp)      timeout <= 1'b1;
  end
`else
  logic unused_wd;
  assign unused_wd = ^{10'(TIMEOUT_CYCLES)};
  assign wd_exp    = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= COEF;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COEF:    if (fe && idx == 2'd2)     state_nxt = STREAM;
      STREAM:  if (fe)                    state_nxt = PROC;
      PROC:    if (filt_done || wd_exp)   state_nxt = STREAM;
      default:                            state_nxt = COEF;
    endcase
    if (coef_reload) state_nxt = COEF;
  end

  assign busy = (state == PROC);

  // Reload wins over everything; coef fields keep old contents until rewritten.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx          <= 2'd0;
      coef         <= '0;
      coef_valid   <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      tx_word      <= '0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (coef_reload) begin
        idx        <= 2'd0;
        coef_valid <= 1'b0;
        overrun    <= 1'b0;
      end else begin
        case (state)
          COEF: if (fe) begin
            coef[10*idx +: 10] <= rx_word;
            if (idx == 2'd2) begin
              idx        <= 2'd0;
              coef_valid <= 1'b1;
            end else begin
              idx <= idx + 2'd1;
            end
          end
          STREAM: if (fe) begin
            sample       <= rx_word;
            sample_valid <= 1'b1;
          end
          PROC: begin
            if (fe)             overrun <= 1'b1;
            if (filt_done)      tx_word <= filtered;
            else if (wd_exp)    tx_word <= 10'h3FF;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sample_sequencer.sv
// Cycle-stepped bench for sample_sequencer: directed scenarios plus random traffic
// scored against a frame/event-level reference model.
module tb_sample_sequencer;

  localparam int S  = 3;
  localparam int TO = 8;
`ifdef SEQ_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif
  localparam int M_COEF = 0, M_STREAM = 1, M_PROC = 2;

  logic        clk = 1'b0, reset = 1'b0, ss_n = 1'b1, coef_reload = 1'b0, filt_done = 1'b0;
  logic [9:0]  rx_word = '0, filtered = '0;
  logic [29:0] coef;
  logic        coef_valid, sample_valid, busy, overrun, timeout;
  logic [9:0]  sample, tx_word;

  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  sample_sequencer #(.SYNC_STAGES(S), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .ss_n(ss_n), .rx_word(rx_word),
    .coef_reload(coef_reload), .filtered(filtered), .filt_done(filt_done),
    .coef(coef), .coef_valid(coef_valid), .sample(sample), .sample_valid(sample_valid),
    .tx_word(tx_word), .busy(busy), .overrun(overrun), .timeout(timeout)
  );

  // reference model state
  int         m_mode, m_idx, m_wait;
  logic [9:0] m_c[3];
  logic [9:0] m_smp, m_tx;
  logic       m_cv, m_sv, m_ov, m_to;
  logic       hist[S+2];
  logic       g_ss;
  int         g_left;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_COEF; m_idx = 0; m_wait = 0;
    for (int i = 0; i < 3; i++) m_c[i] = '0;
    m_smp = '0; m_tx = '0; m_cv = 0; m_sv = 0; m_ov = 0; m_to = 0;
    for (int i = 0; i < S + 2; i++) hist[i] = 1'b1;
  endtask

  task automatic model_edge(input logic rl, input logic fd, input logic [9:0] f, input logic fe);
    m_sv = 1'b0;
    if (rl) begin
      m_mode = M_COEF; m_idx = 0; m_cv = 0; m_ov = 0; m_to = 0;
    end else if (m_mode == M_COEF) begin
      if (fe) begin
        m_c[m_idx] = rx_word;
        if (m_idx == 2) begin m_cv = 1; m_mode = M_STREAM; m_idx = 0; end
        else m_idx++;
      end
    end else if (m_mode == M_STREAM) begin
      if (fe) begin m_smp = rx_word; m_sv = 1; m_mode = M_PROC; m_wait = 0; end
    end else begin
      m_wait++;
      if (fe) m_ov = 1;
      if (fd) begin m_tx = f; m_mode = M_STREAM; end
      else if (WD && m_wait == TO) begin m_to = 1; m_tx = 10'h3FF; m_mode = M_STREAM; end
    end
  endtask

  task automatic check_all();
    chk("coef",         coef,         {m_c[2], m_c[1], m_c[0]});
    chk("coef_valid",   coef_valid,   m_cv);
    chk("sample",       sample,       m_smp);
    chk("sample_valid", sample_valid, m_sv);
    chk("tx_word",      tx_word,      m_tx);
    chk("busy",         busy,         m_mode == M_PROC);
    chk("overrun",      overrun,      m_ov);
    chk("timeout",      timeout,      m_to);
  endtask

  // One clock: drive at the falling edge, model the rising edge, compare 1ns later.
  // A frame end is seen S+1 rising edges after ss_n is first sampled high.
  task automatic step(input logic rl, input logic fd, input logic [9:0] f, input logic ssv);
    logic fe;
    coef_reload = rl; filt_done = fd; filtered = f; ss_n = ssv;
    @(posedge clk);
    for (int i = S + 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = ssv;
    fe = hist[S] && !hist[S+1];
    model_edge(rl, fd, f, fe);
    #1 check_all();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 10'h0, 1'b1);
  endtask

  // one low cycle, then rise with w; the frame end lands on the S-th trailing step
  task automatic frame(input logic [9:0] w, input int tail);
    step(1'b0, 1'b0, 10'h0, 1'b0);
    rx_word = w;
    step(1'b0, 1'b0, 10'h0, 1'b1);
    idle(tail);
  endtask

  task automatic do_reset();
    reset = 1'b0; ss_n = 1'b1; coef_reload = 1'b0; filt_done = 1'b0;
    #1;
    model_reset();
    chk("rst_coef",  coef, 0);
    chk("rst_cv",    coef_valid, 0);
    chk("rst_smp",   sample, 0);
    chk("rst_sv",    sample_valid, 0);
    chk("rst_tx",    tx_word, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_ov",    overrun, 0);
    chk("rst_to",    timeout, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    idle(2);

    frame(10'h001, S + 1);
    frame(10'h002, S + 1);
    frame(10'h003, S + 1);
    chk("load_coef", coef, 30'h00300801);
    chk("load_cv",   coef_valid, 1);

    frame(10'h155, S);
    chk("strm_sv",   sample_valid, 1);
    chk("strm_smp",  sample, 10'h155);
    step(1'b0, 1'b1, 10'h0AA, 1'b1);
    chk("strm_sv_1", sample_valid, 0);
    chk("done_tx",   tx_word, 10'h0AA);
    chk("done_busy", busy, 0);

    frame(10'h155, S);
    frame(10'h2C3, S);
    chk("ovr_flag",  overrun, 1);
    chk("ovr_smp",   sample, 10'h155);
    chk("ovr_busy",  busy, 1);
    step(1'b1, 1'b0, 10'h0, 1'b1);
    chk("rld_ov",    overrun, 0);
    chk("rld_cv",    coef_valid, 0);
    chk("rld_busy",  busy, 0);
    chk("rld_tx",    tx_word, 10'h0AA);

    frame(10'h011, S + 1);
    frame(10'h022, S + 1);
    frame(10'h033, S + 1);
    chk("reload_coef", coef, {10'h033, 10'h022, 10'h011});
    frame(10'h111, S);
    step(1'b0, 1'b0, 10'h0, 1'b0);
    rx_word = 10'h222;
    step(1'b0, 1'b0, 10'h0, 1'b1);
    idle(S - 1);
    step(1'b0, 1'b1, 10'h0AB, 1'b1);
    chk("coin_tx",   tx_word, 10'h0AB);
    chk("coin_ov",   overrun, 1);
    chk("coin_busy", busy, 0);
    chk("coin_smp",  sample, 10'h111);

    // reload coincident with a STREAM frame end drops it without overrun
    step(1'b1, 1'b0, 10'h0, 1'b1);
    frame(10'h044, S + 1);
    frame(10'h055, S + 1);
    frame(10'h066, S + 1);
    step(1'b0, 1'b0, 10'h0, 1'b0);
    rx_word = 10'h1EE;
    step(1'b0, 1'b0, 10'h0, 1'b1);
    idle(S - 1);
    step(1'b1, 1'b0, 10'h0, 1'b1);
    chk("rlfe_ov",   overrun, 0);
    chk("rlfe_smp",  sample, 10'h111);
    chk("rlfe_cv",   coef_valid, 0);

    frame(10'h077, S + 1);
    frame(10'h088, S + 1);
    frame(10'h099, S + 1);
    frame(10'h0F0, S);
`ifdef SEQ_WATCHDOG_EN
    idle(TO + 2);
    chk("wd_to",   timeout, 1);
    chk("wd_tx",   tx_word, 10'h3FF);
    chk("wd_busy", busy, 0);
    frame(10'h0F1, S);
`else
    idle(1000);
    chk("nowd_busy", busy, 1);
    chk("nowd_to",   timeout, 0);
`endif

    // reset mid-PROC, release with ss_n high
    do_reset();
    idle(S + 3);
    chk("post_rst_sv",   sample_valid, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_coef", coef, 0);

    g_ss = 1'b1; g_left = 2;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 999) < 3) begin
        do_reset();
        g_ss = 1'b1; g_left = 2;
      end
      if (g_left == 0) begin
        if (g_ss) begin
          g_ss = 1'b0; g_left = $urandom_range(1, 3);
        end else begin
          g_ss = 1'b1; rx_word = 10'($urandom); g_left = $urandom_range(1, 9);
        end
      end
      g_left--;
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 12, 10'($urandom), g_ss);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
